// File: rtl/mem_resp.sv
// mem_resp: byte RAM with a registered read port, plus an optional
// memory-mapped IO window (TX/RX byte FIFOs, status, halt).
// The IO window is built only when MEM_RESP_IO_EN is defined. Without it,
// every address maps to RAM and the stream ports are tied off.
// FIFO_DEPTH must be a power of two and at least 2.
module mem_resp #(
   parameter int ADDR_W     = 17,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        halt
);

   logic [7:0]        ram [2**ADDR_W];
   logic [ADDR_W-1:0] ram_a;
   logic              io_sel;
   logic [7:0]        io_rdata;
   logic              unused_in;

   assign ram_a     = mem_a[ADDR_W-1:0];
   // Fold every input that one of the two builds leaves unread.
   assign unused_in = ^{mem_a, tx_ready, rx_valid, rx_data};

`ifdef MEM_RESP_IO_EN
   localparam int FW = $clog2(FIFO_DEPTH);
   localparam int PW = FW + 1;
   // Write and read pointers differ only in the wrap bit when the FIFO is full.
   localparam logic [PW-1:0] FULL_X = PW'(FIFO_DEPTH);

   logic          io_dat, io_sts;
   logic [7:0]    tx_mem [FIFO_DEPTH];
   logic [7:0]    rx_mem [FIFO_DEPTH];
   logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
   logic          tx_full, tx_empty, rx_full, rx_empty;
   logic          tx_push_req, tx_push, tx_pop, rx_push, rx_pop;
   logic          ovf, halt_q;

   assign io_sel   = (mem_a[17:16] == 2'b11);
   assign io_dat   = io_sel && (mem_a[15:0] == 16'h0000);
   assign io_sts   = io_sel && (mem_a[15:0] == 16'h0004);

   assign tx_empty = (tx_wp == tx_rp);
   assign tx_full  = (tx_wp == (tx_rp ^ FULL_X));
   assign rx_empty = (rx_wp == rx_rp);
   assign rx_full  = (rx_wp == (rx_rp ^ FULL_X));

   // A push into a full TX FIFO still lands when the consumer frees a slot
   // in the same cycle.
   assign tx_pop      = !tx_empty && tx_ready;
   assign tx_push_req = rdy && mem_wr && io_dat;
   assign tx_push     = tx_push_req && (!tx_full || tx_pop);
   assign rx_push     = rx_valid && !rx_full;
   assign rx_pop      = rdy && !mem_wr && io_dat && !rx_empty;

   assign tx_valid = !tx_empty;
   assign tx_data  = tx_mem[tx_rp[FW-1:0]];
   assign rx_ready = !rx_full;
   assign halt     = halt_q;

   // IO read data, taken from state as it stands before this edge.
   always_comb begin
      io_rdata = 8'h00;
      if (io_dat && !rx_empty) io_rdata = rx_mem[rx_rp[FW-1:0]];
      else if (io_sts)         io_rdata = {5'b0, ovf, !rx_empty, tx_full};
   end

   // FIFO storage; no reset needed since pointers gate visibility.
   always_ff @(posedge clk) begin
      if (rst && tx_push) tx_mem[tx_wp[FW-1:0]] <= mem_dout;
      if (rst && rx_push) rx_mem[rx_wp[FW-1:0]] <= rx_data;
   end

   // FIFO pointers, sticky overflow and halt.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_wp  <= '0;
         tx_rp  <= '0;
         rx_wp  <= '0;
         rx_rp  <= '0;
         ovf    <= 1'b0;
         halt_q <= 1'b0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + PW'(1);
         if (tx_pop)  tx_rp <= tx_rp + PW'(1);
         if (rx_push) rx_wp <= rx_wp + PW'(1);
         if (rx_pop)  rx_rp <= rx_rp + PW'(1);
         if (tx_push_req && !tx_push)     ovf    <= 1'b1;
         if (rdy && mem_wr && io_sts)     halt_q <= 1'b1;
      end
   end
`else
   assign io_sel   = 1'b0;
   assign io_rdata = 8'h00;
   assign tx_valid = 1'b0;
   assign tx_data  = 8'h00;
   assign rx_ready = 1'b0;
   assign halt     = 1'b0;
`endif

   // RAM write port; contents survive reset but no write occurs during it.
   always_ff @(posedge clk) begin
      if (rst && rdy && mem_wr && !io_sel) ram[ram_a] <= mem_dout;
   end

   // Registered read data; holds on writes and stalls, cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst)                mem_din <= 8'h00;
      else if (rdy && !mem_wr) mem_din <= io_sel ? io_rdata : ram[ram_a];
   end

endmodule

// File: tb/tb_mem_resp.sv
// Directed bench for mem_resp. RAM checks run in every build; the IO window
// checks run when MEM_RESP_IO_EN is defined, the tie-off checks otherwise.
module tb_mem_resp;
   logic        clk = 1'b0;
   logic        rst, rdy, mem_wr, tx_ready, rx_valid;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout, rx_data, mem_din, tx_data;
   logic        tx_valid, rx_ready, halt;
   int          nvec = 0;
   int          nmis = 0;

   mem_resp #(.ADDR_W(17), .FIFO_DEPTH(8)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .mem_a(mem_a), .mem_dout(mem_dout),
      .mem_wr(mem_wr), .mem_din(mem_din), .tx_valid(tx_valid),
      .tx_data(tx_data), .tx_ready(tx_ready), .rx_valid(rx_valid),
      .rx_data(rx_data), .rx_ready(rx_ready), .halt(halt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [7:0] d);
      rdy = 1'b1; mem_wr = 1'b1; mem_a = a; mem_dout = d;
      step();
   endtask

   task automatic rd(input logic [31:0] a);
      rdy = 1'b1; mem_wr = 1'b0; mem_a = a;
      step();
   endtask

   initial begin
      rst = 1'b0; rdy = 1'b1; mem_wr = 1'b0; mem_a = '0; mem_dout = '0;
      tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
      step(); step();
      chk("rst_din", mem_din, 8'h00);
      chk("rst_txv", tx_valid, 1'b0);
      chk("rst_halt", halt, 1'b0);
`ifdef MEM_RESP_IO_EN
      chk("rst_rxr", rx_ready, 1'b1);
`else
      chk("rst_rxr", rx_ready, 1'b0);
`endif
      rst = 1'b1;

      // read-after-write, back-to-back reads, write holds mem_din
      wr(32'h10, 8'hA5);
      rd(32'h10);          chk("raw_a5", mem_din, 8'hA5);
      wr(32'h11, 8'h3C);
      wr(32'h12, 8'hC3);
      rd(32'h11);          chk("b2b_0", mem_din, 8'h3C);
      rd(32'h12);          chk("b2b_1", mem_din, 8'hC3);
      wr(32'h13, 8'h77);   chk("wr_hold", mem_din, 8'hC3);
      wr(32'h1FFFF, 8'h9E);
      rd(32'h1FFFF);       chk("top_addr", mem_din, 8'h9E);

      // stall: no write, mem_din frozen
      wr(32'h20, 8'h11);
      rd(32'h20);          chk("pre_stall", mem_din, 8'h11);
      rdy = 1'b0; mem_wr = 1'b1; mem_a = 32'h20; mem_dout = 8'hFF;
      step(); step();      chk("stall_wr", mem_din, 8'h11);
      mem_wr = 1'b0; mem_a = 32'h10;
      step();              chk("stall_rd", mem_din, 8'h11);
      rd(32'h20);          chk("stall_old", mem_din, 8'h11);

`ifdef MEM_RESP_IO_EN
      // TX fill past full, overflow status, ordered drain
      for (int i = 1; i <= 9; i++) wr(32'h30000, 8'(i));
      chk("tx_v_full", tx_valid, 1'b1);
      rd(32'h30004);       chk("sts_ovf", mem_din, 8'h05);
      tx_ready = 1'b1; mem_a = 32'h0;
      for (int i = 1; i <= 8; i++) begin
         chk("tx_drain", tx_data, 32'(i));
         step();
      end
      chk("tx_empty", tx_valid, 1'b0);

      // push and pop on the same edge while full
      tx_ready = 1'b0;
      for (int i = 0; i < 8; i++) wr(32'h30000, 8'(8'h10 + i));
      tx_ready = 1'b1;
      wr(32'h30000, 8'h18);
      tx_ready = 1'b0;
      rd(32'h30004);       chk("sts_full_pp", mem_din, 8'h05);
      tx_ready = 1'b1; mem_a = 32'h0;
      for (int i = 0; i < 8; i++) begin
         chk("tx_pp_drain", tx_data, 32'(8'h11 + i));
         step();
      end
      chk("tx_pp_empty", tx_valid, 1'b0);
      tx_ready = 1'b0;

      // RX receive and pop through the data register
      rx_valid = 1'b1; rx_data = 8'h41; step();
      rx_data = 8'h42; step();
      rx_valid = 1'b0;
      rd(32'h30004);       chk("sts_rx", mem_din, 8'h06);
      rd(32'h30000);       chk("rx_0", mem_din, 8'h41);
      rd(32'h30000);       chk("rx_1", mem_din, 8'h42);
      rd(32'h30000);       chk("rx_empty", mem_din, 8'h00);
      rd(32'h30008);       chk("io_other", mem_din, 8'h00);

      // halt is sticky until reset
      wr(32'h30004, 8'h00);
      chk("halt_set", halt, 1'b1);
      rd(32'h10);
      chk("halt_stay", halt, 1'b1);
`else
      // no IO window: 0x30000 aliases RAM 0x10000
      wr(32'h30000, 8'h5A);
      chk("noio_txv", tx_valid, 1'b0);
      rd(32'h10000);       chk("noio_alias", mem_din, 8'h5A);
      chk("noio_txd", tx_data, 8'h00);
      chk("noio_rxr", rx_ready, 1'b0);
      wr(32'h30004, 8'h01);
      chk("noio_halt", halt, 1'b0);
`endif

      // reset during a read discards its result; RAM survives
      rd(32'h12);          chk("pre_rst", mem_din, 8'hC3);
      rst = 1'b0; mem_a = 32'h10;
      step();              chk("rst_discard", mem_din, 8'h00);
      chk("rst_halt2", halt, 1'b0);
      chk("rst_txv2", tx_valid, 1'b0);
      rst = 1'b1;
`ifdef MEM_RESP_IO_EN
      chk("rst_rxr2", rx_ready, 1'b1);
      rd(32'h30004);       chk("rst_sts", mem_din, 8'h00);
`endif
      rd(32'h10);          chk("ram_keep", mem_din, 8'hA5);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
